noise_addr_gen: RTL



---
 rtl/noise_addr_gen_if.sv | 50 +++++
 rtl/noise_addr_gen.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/noise_addr_gen_if.sv
// Handshake/bus bundle between the DDS control side and noise_addr_gen.
// master: drives start/stop/rate_div (and seed/seed_load when
// NOISE_SEED_LOAD_EN is defined), receives enables, addresses and strobes.
// slave: the address sequencer itself.
interface noise_addr_gen_if;

  logic        start;
  logic        stop;
  logic [15:0] rate_div;
`ifdef NOISE_SEED_LOAD_EN
  logic [31:0] seed;
  logic        seed_load;
`endif
  logic        noise_en;
  logic [10:0] orbit_sin_addr;
  logic [9:0]  orbit_log_addr;
  logic        noise_valid;
  logic        busy;

  modport master (
`ifdef NOISE_SEED_LOAD_EN
    output seed,
    output seed_load,
`endif
    output start,
    output stop,
    output rate_div,
    input  noise_en,
    input  orbit_sin_addr,
    input  orbit_log_addr,
    input  noise_valid,
    input  busy
  );

  modport slave (
`ifdef NOISE_SEED_LOAD_EN
    input  seed,
    input  seed_load,
`endif
    input  start,
    input  stop,
    input  rate_div,
    output noise_en,
    output orbit_sin_addr,
    output orbit_log_addr,
    output noise_valid,
    output busy
  );

endinterface

// File: rtl/noise_addr_gen.sv
// Address sequencer for the noise datapath: a 32-bit Galois LFSR paced by
// a rate divider feeds registered sine/log ROM addresses, and a sample
// strobe is regenerated PIPE_LAT cycles later to line up with the product.
//
// Ports:
//   clk100  100 MHz system clock, rising edge
//   rst     asynchronous active-high reset
//   bus     noise_addr_gen_if.slave:
//             start, stop        single-cycle control pulses
//             rate_div           sample period minus one (clk100 cycles)
//             seed, seed_load    LFSR load (only with NOISE_SEED_LOAD_EN)
//             noise_en           ROM/multiplier enable (RUN or DRAIN)
//             orbit_sin_addr     sine ROM address  = lfsr[31:21]
//             orbit_log_addr     log ROM address   = lfsr[9:0]
//             noise_valid        product-aligned new-sample strobe
//             busy               high in RUN or DRAIN
//
// Build option: define NOISE_SEED_LOAD_EN to add the seed load port.
module noise_addr_gen #(
  parameter int unsigned PIPE_LAT  = 3,
  parameter logic [31:0] LFSR_SEED = 32'h0000_0001
) (
  input  logic            clk100,
  input  logic            rst,
  noise_addr_gen_if.slave bus
);

  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam int unsigned DW =
    (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [DW-1:0] DRN_LAST = DW'(PIPE_LAT - 1);

  logic [1:0]          state;
  logic [1:0]          state_nx;
  logic [31:0]         lfsr;
  logic [31:0]         lfsr_nx;
  logic [31:0]         lfsr_step;
  logic [31:0]         lfsr_src;
  logic [15:0]         div_cnt;
  logic [15:0]         div_cnt_nx;
  logic [DW-1:0]       drn_cnt;
  logic [DW-1:0]       drn_cnt_nx;
  logic [10:0]         sin_q;
  logic [10:0]         sin_nx;
  logic [9:0]          log_q;
  logic [9:0]          log_nx;
  logic                upd;
  logic                upd_nx;
  logic                hit;
  logic [PIPE_LAT-1:0] vld_sr;

  function automatic logic [31:0] lfsr_next(
    input logic [31:0] v
  );
    lfsr_next = v[0] ? ((v >> 1) ^ LFSR_MASK)
                     : (v >> 1);
  endfunction

  assign lfsr_step = lfsr_next(lfsr);

  // A zero seed would lock the LFSR, so it
  // is replaced by the reset seed.
`ifdef NOISE_SEED_LOAD_EN
  logic        ld;
  logic [31:0] seed_val;

  assign ld       = bus.seed_load && (state == IDLE);
  assign seed_val = (bus.seed == '0) ? LFSR_SEED
                                     : bus.seed;
  assign lfsr_src = ld ? seed_val : lfsr;
`else
  assign lfsr_src = lfsr;
`endif

  // Equality compare: if rate_div drops below
  // div_cnt, the count wraps through 16'hFFFF.
  assign hit = (div_cnt == bus.rate_div);

  always_comb begin
    state_nx   = state;
    lfsr_nx    = lfsr;
    div_cnt_nx = div_cnt;
    drn_cnt_nx = drn_cnt;
    sin_nx     = sin_q;
    log_nx     = log_q;
    upd_nx     = 1'b0;
    unique case (state)
      IDLE: begin
        lfsr_nx = lfsr_src;
        if (bus.start) begin
          state_nx   = RUN;
          div_cnt_nx = '0;
          upd_nx     = 1'b1;
          sin_nx     = lfsr_src[31:21];
          log_nx     = lfsr_src[9:0];
        end
      end
      RUN: begin
        if (bus.stop) begin
          // stop wins over a same-cycle step
          state_nx   = DRAIN;
          drn_cnt_nx = '0;
        end else if (hit) begin
          lfsr_nx    = lfsr_step;
          div_cnt_nx = '0;
          upd_nx     = 1'b1;
          sin_nx     = lfsr_step[31:21];
          log_nx     = lfsr_step[9:0];
        end else begin
          div_cnt_nx = div_cnt + 16'd1;
        end
      end
      DRAIN: begin
        // hold the enable until the last
        // in-flight product has emerged
        if (drn_cnt == DRN_LAST) begin
          state_nx = IDLE;
        end else begin
          drn_cnt_nx = drn_cnt + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      lfsr    <= LFSR_SEED;
      div_cnt <= '0;
      drn_cnt <= '0;
    end else begin
      state   <= state_nx;
      lfsr    <= lfsr_nx;
      div_cnt <= div_cnt_nx;
      drn_cnt <= drn_cnt_nx;
    end
  end

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      sin_q <= '0;
      log_q <= '0;
      upd   <= 1'b0;
    end else begin
      sin_q <= sin_nx;
      log_q <= log_nx;
      upd   <= upd_nx;
    end
  end

  // upd marks the first cycle a new address is
  // presented; the ROM + multiplier latency is
  // matched by delaying it PIPE_LAT cycles.
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      vld_sr <= '0;
    end else begin
      vld_sr <= (vld_sr << 1) | PIPE_LAT'(upd);
    end
  end

  assign bus.noise_en       = (state != IDLE);
  assign bus.busy           = (state != IDLE);
  assign bus.orbit_sin_addr = sin_q;
  assign bus.orbit_log_addr = log_q;
  assign bus.noise_valid    = vld_sr[PIPE_LAT-1];

endmodule
